// File: rtl/pc_gen_if.sv
// Fetch handshake between the PC generator and instruction fetch.
//   current_pc  : fetch address presented by the generator
//   fetch_valid : current_pc may be fetched this cycle
//   fetch_ready : fetch accepts current_pc this cycle
// master = pc_gen side, slave = instruction-fetch side.
interface pc_gen_if #(
  parameter int unsigned XLEN = 32
) ();
  logic [XLEN-1:0] current_pc;
  logic            fetch_valid;
  logic            fetch_ready;

  modport master (
    output current_pc,
    output fetch_valid,
    input  fetch_ready
  );

  modport slave (
    input  current_pc,
    input  fetch_valid,
    output fetch_ready
  );
endinterface

// File: rtl/pc_gen.sv
// Fetch-address generator for the pipeline front end.
// Holds the fetch PC and offers it through a valid/ready handshake. The next
// PC is chosen by priority: trap vector, ALU redirect, return-address-stack
// prediction, sequential increment, hold. A post-reset hold window keeps
// fetch_valid low for RST_HOLD cycles after reset release.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   stop            : stall; blocks sequential and RAS advance only
//   trap            : next PC = TRAP_VEC, flushes the RAS
//   redirect        : next PC = from_alu
//   call            : push call_ret_addr onto the RAS on advance
//   ret             : predict next PC from the RAS top on advance
//   fetch           : handshake (current_pc, fetch_valid out; fetch_ready in)
//   ras_empty/full  : RAS occupancy flags from the registered count
module pc_gen #(
  parameter int unsigned     XLEN      = 32,
  parameter int unsigned     INC       = 4,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter logic [XLEN-1:0] TRAP_VEC  = 'h100,
  parameter int unsigned     RAS_DEPTH = 4,
  parameter int unsigned     RST_HOLD  = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stop,
  input  logic            trap,
  input  logic            redirect,
  input  logic [XLEN-1:0] from_alu,
  input  logic            call,
  input  logic [XLEN-1:0] call_ret_addr,
  input  logic            ret,
  pc_gen_if.master        fetch,
  output logic            ras_empty,
  output logic            ras_full
);

  localparam int unsigned     ALIGN      = $clog2(INC);
  localparam int unsigned     PW         = $clog2(RAS_DEPTH);
  localparam int unsigned     HW         = (RST_HOLD == 0) ? 1 : $clog2(RST_HOLD + 1);
  localparam logic [XLEN-1:0] ALIGN_MASK = ~((XLEN'(1) << ALIGN) - XLEN'(1));
  localparam logic [XLEN-1:0] TRAP_TGT   = TRAP_VEC & ALIGN_MASK;
  localparam logic [XLEN-1:0] STEP       = XLEN'(INC);
  localparam logic [PW:0]     CNT_FULL   = (PW + 1)'(RAS_DEPTH);

  logic [XLEN-1:0] pc_q;
  logic            valid_q;
  logic [HW-1:0]   hold_cnt;
  logic [XLEN-1:0] ras_mem [RAS_DEPTH];
  logic [PW-1:0]   tp;
  logic [PW:0]     cnt;

  logic            adv;
  logic            ras_ok;
  logic            push;
  logic            pop;
  logic            ras_has;
  logic [XLEN-1:0] ras_top;
  logic [XLEN-1:0] ret_aligned;

  assign fetch.current_pc  = pc_q;
  assign fetch.fetch_valid = valid_q;

  // valid_q is only set once the hold window has expired, so adv is
  // implicitly suppressed during hold.
  assign adv         = valid_q & fetch.fetch_ready & ~stop;
  // A trap or redirect in the same cycle cancels any RAS activity.
  assign ras_ok      = adv & ~trap & ~redirect;
  assign push        = ras_ok & call;
  assign pop         = ras_ok & ret;
  assign ras_has     = (cnt != '0);
  assign ras_top     = ras_mem[tp];
  assign ret_aligned = call_ret_addr & ALIGN_MASK;

  assign ras_empty   = (cnt == '0);
  assign ras_full    = (cnt == CNT_FULL);

  // PC, handshake valid, hold counter and RAS pointers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q     <= RESET_PC;
      valid_q  <= (RST_HOLD == 0);
      hold_cnt <= HW'(RST_HOLD);
      tp       <= '0;
      cnt      <= '0;
    end else if (hold_cnt != '0) begin
      // Hold window: PC pinned, all control inputs ignored.
      pc_q     <= RESET_PC;
      hold_cnt <= hold_cnt - HW'(1);
      valid_q  <= (hold_cnt == HW'(1));
    end else begin
      valid_q <= 1'b1;

      if (trap) begin
        pc_q <= TRAP_TGT;
        cnt  <= '0;
      end else if (redirect) begin
        pc_q <= from_alu & ALIGN_MASK;
      end else if (adv) begin
        if (ret && ras_has) begin
          pc_q <= ras_top;
        end else begin
          pc_q <= pc_q + STEP;
        end
      end

      if (push && pop) begin
        // Call and return together: top replaced in place, pointers kept.
        tp  <= tp;
        cnt <= cnt;
      end else if (push) begin
        tp <= tp + PW'(1);
        // Saturating count: once full, the push overwrites the oldest slot.
        if (cnt != CNT_FULL) begin
          cnt <= cnt + (PW + 1)'(1);
        end
      end else if (pop && ras_has) begin
        tp  <= tp - PW'(1);
        cnt <= cnt - (PW + 1)'(1);
      end
    end
  end

  // RAS storage; contents need no reset because cnt gates every read.
  always_ff @(posedge clk) begin
    if (push && pop) begin
      ras_mem[tp] <= ret_aligned;
    end else if (push) begin
      ras_mem[tp + PW'(1)] <= ret_aligned;
    end
  end

endmodule
